multicycle_alu: RTL

MULTICYCLE_ALU -- requirements
Module: multicycle_alu

---
 rtl/multicycle_alu.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_alu.sv
// multicycle_alu: single-cycle ALU ops plus iterative unsigned shift-add MUL and restoring DIV.
// Define MULTICYCLE_ALU_DIV_EN to build the divider; without it opcode 1011 acts as undefined.
module multicycle_alu #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   operand1,
  input  logic [WIDTH-1:0]   operand2,
  input  logic [3:0]         alu_control,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result,
  output logic [WIDTH-1:0]   result_hi,
  output logic               zero,
  output logic               div_by_zero,
  output logic [1:0]         dbg_state
);

  // Handshake: start is sampled only while busy=0 (IDLE); done is a one-cycle
  // pulse and result/result_hi/zero/div_by_zero hold until the next done.

  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_XOR = 4'b1001;
  localparam logic [3:0] OP_NOR = 4'b1010;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_MUL = 4'b1000;
  localparam logic [3:0] OP_SLL = 4'b1100;
  localparam logic [3:0] OP_SRL = 4'b0011;
  localparam logic [3:0] OP_SRA = 4'b1101;
`ifdef MULTICYCLE_ALU_DIV_EN
  localparam logic [3:0] OP_DIV = 4'b1011;
`endif

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic                 done_q, done_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic [WIDTH-1:0]     result_hi_q, result_hi_d;
  logic                 zero_q, zero_d;
  logic                 dbz_q, dbz_d;

  logic [WIDTH-1:0]     sc_result;
  logic                 shamt_big;
  logic                 last_step;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;

  assign shamt_big = (32'(shamt) >= 32'(WIDTH));
  assign last_step = (cnt_q == CNT_W'(WIDTH - 1));

  always_comb begin
    sc_result = '0;
    case (alu_control)
      OP_ADD:  sc_result = operand1 + operand2;
      OP_SUB:  sc_result = operand1 - operand2;
      OP_AND:  sc_result = operand1 & operand2;
      OP_OR:   sc_result = operand1 | operand2;
      OP_XOR:  sc_result = operand1 ^ operand2;
      OP_NOR:  sc_result = ~(operand1 | operand2);
      OP_SLT:  sc_result = {{(WIDTH-1){1'b0}}, (operand1 < operand2)};
      OP_SLL:  sc_result = shamt_big ? '0 : (operand1 << shamt);
      OP_SRL:  sc_result = shamt_big ? '0 : (operand1 >> shamt);
      OP_SRA:  sc_result = shamt_big ? {WIDTH{operand1[WIDTH-1]}}
                                     : WIDTH'($signed(operand1) >>> shamt);
      default: sc_result = '0;
    endcase
  end

  // prod_q holds {partial_hi, remaining multiplier bits}; one multiplier bit retires per step.
  always_comb begin
    mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    mul_next = {mul_sum, prod_q[WIDTH-1:1]};
  end

`ifdef MULTICYCLE_ALU_DIV_EN
  // Divide reuses prod_q as {remainder, dividend/quotient} and mcand_q as the divisor.
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic               div_ge;
  logic [WIDTH-1:0]   rem_next;
  logic [WIDTH-1:0]   quot_next;

  always_comb begin
    div_shift = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, mcand_q};
    div_ge    = (div_shift >= {1'b0, mcand_q});
    rem_next  = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    quot_next = {prod_q[WIDTH-2:0], div_ge};
  end
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    prod_d      = prod_q;
    mcand_d     = mcand_q;
    done_d      = 1'b0;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    dbz_d       = dbz_q;
    zero_d      = zero_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          cnt_d = '0;
          case (alu_control)
            OP_MUL: begin
              state_d = S_MUL;
              mcand_d = operand1;
              prod_d  = {{WIDTH{1'b0}}, operand2};
            end
`ifdef MULTICYCLE_ALU_DIV_EN
            OP_DIV: begin
              if (operand2 == '0) begin
                state_d     = S_FIN;
                done_d      = 1'b1;
                result_d    = '1;
                result_hi_d = operand1;
                dbz_d       = 1'b1;
              end else begin
                state_d = S_DIV;
                mcand_d = operand2;
                prod_d  = {{WIDTH{1'b0}}, operand1};
              end
            end
`endif
            default: begin
              state_d     = S_FIN;
              done_d      = 1'b1;
              result_d    = sc_result;
              result_hi_d = '0;
              dbz_d       = 1'b0;
            end
          endcase
        end
      end
      S_MUL: begin
        prod_d = mul_next;
        cnt_d  = cnt_q + 1'b1;
        if (last_step) begin
          state_d     = S_FIN;
          done_d      = 1'b1;
          result_d    = mul_next[WIDTH-1:0];
          result_hi_d = mul_next[2*WIDTH-1:WIDTH];
          dbz_d       = 1'b0;
        end
      end
`ifdef MULTICYCLE_ALU_DIV_EN
      S_DIV: begin
        prod_d = {rem_next, quot_next};
        cnt_d  = cnt_q + 1'b1;
        if (last_step) begin
          state_d     = S_FIN;
          done_d      = 1'b1;
          result_d    = quot_next;
          result_hi_d = rem_next;
          dbz_d       = 1'b0;
        end
      end
`endif
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (done_d) zero_d = (result_d == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      prod_q      <= '0;
      mcand_q     <= '0;
      done_q      <= 1'b0;
      result_q    <= '0;
      result_hi_q <= '0;
      zero_q      <= 1'b1;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      prod_q      <= prod_d;
      mcand_q     <= mcand_d;
      done_q      <= done_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      zero_q      <= zero_d;
      dbz_q       <= dbz_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign result      = result_q;
  assign result_hi   = result_hi_q;
  assign zero        = zero_q;
  assign div_by_zero = dbz_q;
  assign dbg_state   = state_q;

endmodule
